// File: rtl/rgb2raw_mosaic_if.sv
// Stream bundle around the re-mosaic stage: 24-bit RGB in, 8-bit Bayer raw out.
// The slave modport is the re-mosaic block's view; master is the surrounding pipeline.
interface rgb2raw_mosaic_if;
  logic [23:0] rgb_pixel;
  logic        rgb_valid;
  logic        rgb_ready;
  logic [1:0]  sensor_pattern;
  logic [7:0]  raw_pixel;
  logic        raw_valid;
  logic        raw_ready;
  logic        raw_sof;
  logic        raw_eol;
  logic        raw_eof;

  modport slave (
    input  rgb_pixel, rgb_valid, sensor_pattern, raw_ready,
    output rgb_ready, raw_pixel, raw_valid, raw_sof, raw_eol, raw_eof
  );

  modport master (
    output rgb_pixel, rgb_valid, sensor_pattern, raw_ready,
    input  rgb_ready, raw_pixel, raw_valid, raw_sof, raw_eol, raw_eof
  );
endinterface

// File: rtl/rgb2raw_mosaic.sv
// Re-mosaics an RGB stream into single-channel Bayer raw through a 1-deep output register,
// tracking frame geometry and latching the Bayer order at each frame start.
module rgb2raw_mosaic #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic            clk,
  input  logic            reset_n,
  rgb2raw_mosaic_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  // The pattern code equals the {row,col} phase holding R; B sits diagonally opposite.
  function automatic chan_e chan_of(input logic [1:0] pattern, input logic row_odd,
                                    input logic col_odd);
    logic [1:0] phase;
    phase = {row_odd, col_odd};
    if (phase == pattern) begin
      chan_of = CH_R;
    end else if (phase == ~pattern) begin
      chan_of = CH_B;
    end else begin
      chan_of = CH_G;
    end
  endfunction

  function automatic logic [7:0] pick(input chan_e ch, input logic [23:0] rgb);
    case (ch)
      CH_R:    pick = rgb[23:16];
      CH_G:    pick = rgb[15:8];
      CH_B:    pick = rgb[7:0];
      default: pick = 8'h00;
    endcase
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    pattern_q, pattern_d;
  logic [7:0]    raw_pixel_q, raw_pixel_d;
  logic          raw_valid_q, raw_valid_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;

  logic          rgb_ready_s;
  logic          accept_s;
  logic          transfer_s;
  logic          first_s;
  logic          col_last_s;
  logic          row_last_s;
  logic [1:0]    pattern_eff_s;

  always_comb begin
    rgb_ready_s   = ~raw_valid_q | bus.raw_ready;
    accept_s      = bus.rgb_valid & rgb_ready_s;
    transfer_s    = raw_valid_q & bus.raw_ready;
    first_s       = (col_q == {CW{1'b0}}) && (row_q == {RW{1'b0}});
    col_last_s    = (col_q == COL_LAST);
    row_last_s    = (row_q == ROW_LAST);
    col_d         = col_q;
    row_d         = row_q;
    pattern_d     = pattern_q;
    raw_pixel_d   = raw_pixel_q;
    raw_valid_d   = raw_valid_q;
    sof_d         = sof_q;
    eol_d         = eol_q;
    eof_d         = eof_q;

    // The frame's first pixel already uses the live pattern input.
    if (first_s) begin
      pattern_eff_s = bus.sensor_pattern;
    end else begin
      pattern_eff_s = pattern_q;
    end

    if (accept_s) begin
      pattern_d   = pattern_eff_s;
      raw_pixel_d = pick(chan_of(pattern_eff_s, row_q[0], col_q[0]), bus.rgb_pixel);
      raw_valid_d = 1'b1;
      sof_d       = first_s;
      eol_d       = col_last_s;
      eof_d       = col_last_s & row_last_s;
      if (col_last_s) begin
        col_d = {CW{1'b0}};
        if (row_last_s) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        row_d = row_q;
      end
    end else if (transfer_s) begin
      raw_valid_d = 1'b0;
      sof_d       = 1'b0;
      eol_d       = 1'b0;
      eof_d       = 1'b0;
    end else begin
      raw_valid_d = raw_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q       <= {CW{1'b0}};
      row_q       <= {RW{1'b0}};
      pattern_q   <= 2'b00;
      raw_pixel_q <= 8'h00;
      raw_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pattern_q   <= pattern_d;
      raw_pixel_q <= raw_pixel_d;
      raw_valid_q <= raw_valid_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
    end
  end

  assign bus.rgb_ready = rgb_ready_s;
  assign bus.raw_pixel = raw_pixel_q;
  assign bus.raw_valid = raw_valid_q;
  assign bus.raw_sof   = sof_q;
  assign bus.raw_eol   = eol_q;
  assign bus.raw_eof   = eof_q;
endmodule

// File: doc/rgb2raw_mosaic.md
Name: rgb2raw_mosaic

Overview:
- Re-mosaics a 24-bit RGB pixel stream into an 8-bit single-channel Bayer raw stream.
- It is the inverse of the demosaic stage: for each pixel it selects R, G or B according to the sensor pattern and the pixel's row/column parity.
- It sits at the pipeline output. It feeds raw-sensor emulation, loopback tests and raw-format storage.
- It tracks frame geometry with row/column counters and supports downstream backpressure.

Parameters:
- IMG_WIDTH, 640, pixels per line (≥2, even).
- IMG_HEIGHT, 480, lines per frame (≥2, even).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- rgb_pixel  input  24  R=[23:16], G=[15:8], B=[7:0].
- rgb_valid  input  1  rgb_pixel valid this cycle.
- rgb_ready  output  1  block accepts rgb_pixel this cycle.
- sensor_pattern  input  2  Bayer order, sampled at frame start: 00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR.
- raw_pixel  output  8  mosaiced sample.
- raw_valid  output  1  raw_pixel valid.
- raw_ready  input  1  downstream accepts raw_pixel.
- raw_sof  output  1  qualifies the first pixel of a frame (row 0, col 0).
- raw_eol  output  1  qualifies the last pixel of a line.
- raw_eof  output  1  qualifies the last pixel of a frame.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Outputs cleared: raw_pixel=0, raw_valid=0, raw_sof=0, raw_eol=0, raw_eof=0.
  - col=0, row=0, latched pattern=00.
  - rgb_ready is combinational and evaluates to 1 while raw_valid=0.
  - Reset mid-frame discards the held output and restarts geometry at (0,0). No partial-frame flush.
- Handshake:
  - Input accept = rgb_valid & rgb_ready.
  - rgb_ready = !raw_valid | raw_ready. This is a 1-deep output register, and allows full throughput when raw_ready=1.
  - Output transfer = raw_valid & raw_ready.
  - While raw_valid=1 and raw_ready=0: raw_pixel, raw_sof, raw_eol and raw_eof are held stable, and no input is accepted.
  - On a cycle with accept: raw_valid<=1 next cycle.
  - On a cycle with transfer and no accept: raw_valid<=0.
  - Simultaneous transfer + accept: the register is replaced by the new pixel and raw_valid stays 1.
- Latency: exactly 1 clk from accept to raw_valid (no backpressure).
- Geometry counters (advance only on accept):
  - col increments and wraps from IMG_WIDTH-1 to 0.
  - On that wrap, row increments and wraps from IMG_HEIGHT-1 to 0.
  - Counter widths are $clog2 of each dimension.
- Pattern latch:
  - On an accept with col==0 and row==0, the effective pattern = sensor_pattern (current input, used for that pixel) and is latched for the rest of the frame.
  - Changes to sensor_pattern mid-frame are ignored until the next frame start.
- Channel select, with p=(row[0],col[0]) using the effective pattern:
  - RGGB: (0,0)R (0,1)G (1,0)G (1,1)B.
  - GRBG: (0,0)G (0,1)R (1,0)B (1,1)G.
  - GBRG: (0,0)G (0,1)B (1,0)R (1,1)G.
  - BGGR: (0,0)B (0,1)G (1,0)G (1,1)R.
  - The selected 8-bit component is passed unmodified. No arithmetic, rounding or saturation.
- Framing flags are registered alongside raw_pixel:
  - sof=(row==0 && col==0).
  - eol=(col==IMG_WIDTH-1).
  - eof=eol && (row==IMG_HEIGHT-1).
  - Flags are meaningful only when raw_valid=1, and are 0 otherwise.
- Idle gaps (rgb_valid=0) neither advance the counters nor alter held output.
- rgb_valid while rgb_ready=0 is not accepted. The upstream block must hold the pixel.

Test Plan:
1. Run with IMG_WIDTH=4, IMG_HEIGHT=2, pattern 00, raw_ready=1, and 8 pixels whose R/G/B are distinct per pixel (e.g. R=0x10+i, G=0x40+i, B=0x80+i). Required: raw = R0,G1,R2,G3,G4,B5,G6,B7 = 0x10,0x41,0x12,0x43,0x44,0x85,0x46,0x87. sof on pixel 0, eol on pixels 3 and 7, eof on pixel 7 only. raw_valid is 1 cycle after each accept.
2. Run all four patterns with the same 4x2 frame. Required: pixel 0 = R/G/G/B and pixel 5 = B/G/G/R for patterns 00/01/10/11 respectively, matching the select table.
3. Backpressure: hold raw_ready=0 for 3 cycles mid-line. Required: rgb_ready=0, raw_pixel and flags stable, col not advancing. On release, the next pixel transfers with no loss or duplication (total output count = 8).
4. Change sensor_pattern from 00 to 11 at pixel 2 of a frame. Required: the rest of that frame still uses RGGB; the next frame's pixel 0 outputs B.
5. Assert reset_n=0 for 1 cycle after pixel 5 is accepted. Required: raw_valid=0 next cycle. The next accepted pixel is treated as (0,0): sof=1 and the pattern is re-latched.
6. Apply back-to-back frames with rgb_valid toggling 1/0 every cycle. Required: the output sequence is identical to scenario 1 per frame, with sof reasserting on pixel 8.
